bitcoin_mem_responder: RTL and testbench

- Memory-side responder for the bitcoin hasher's word-addressed memory port.
- Serves hasher reads with fixed 1-cycle latency and accepts hasher writes.
- Exposes a host load/dump port so the testbench or controller can preload the header and read back results.
- Arbitrates ownership between host and hasher using the hasher's start/done pulses.

---
 rtl/bitcoin_mem_responder.sv | 142 ++++++++++++++
 tb/tb_bitcoin_mem_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bitcoin_mem_responder.sv
// Word-addressed memory responder for the bitcoin hasher with a host load/dump port.
// Optional minimum-result scan over hasher writes is built only when RESULT_MIN_EN is defined.
module bitcoin_mem_responder #(
  parameter int unsigned DEPTH    = 256,
  parameter logic [15:0] MIN_BASE = 16'h0100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  input  logic        hasher_start,
  input  logic        hasher_done,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_ready,
  output logic        host_rvalid,
  output logic [31:0] host_rdata,
  output logic        busy,
  output logic [15:0] wr_count,
  output logic        addr_err,
  output logic        min_valid,
  output logic [31:0] min_data,
  output logic [15:0] min_addr
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    ST_HOST = 1'b0,
    ST_HASH = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [31:0] r_mem [DEPTH];

  logic          w_mem_in_range;
  logic          w_host_in_range;
  logic [AW-1:0] w_mem_idx;
  logic [AW-1:0] w_host_idx;
  logic          w_start_session;
  logic          w_host_xfer;
  logic          w_hash_wr;
  logic          w_err_now;

  assign w_mem_in_range  = (32'(mem_addr) < DEPTH);
  assign w_host_in_range = (32'(host_addr) < DEPTH);
  assign w_mem_idx       = mem_addr[AW-1:0];
  assign w_host_idx      = host_addr[AW-1:0];

  assign busy            = (r_state == ST_HASH);
  assign host_ready      = (r_state == ST_HOST);
  assign w_start_session = (r_state == ST_HOST) && hasher_start;
  assign w_host_xfer     = host_req && host_ready;
  assign w_hash_wr       = (r_state == ST_HASH) && mem_we;

  // Hasher addresses only count as accesses while it owns the memory.
  assign w_err_now = (busy && !w_mem_in_range) || (w_host_xfer && !w_host_in_range);

  // NOTE: next-state logic assigns its default first so no latch can be inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_HOST: if (hasher_start) w_next_state = ST_HASH;
      ST_HASH: if (hasher_done)  w_next_state = ST_HOST;
      default: w_next_state = ST_HOST;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_HOST;
    else          r_state <= w_next_state;
  end

  // NOTE: the array has no reset so it maps onto plain RAM and survives reset_n.
  always_ff @(posedge clk) begin
    if (w_hash_wr && w_mem_in_range)
      r_mem[w_mem_idx] <= mem_write_data;
    else if (w_host_xfer && host_we && w_host_in_range)
      r_mem[w_host_idx] <= host_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_read_data <= '0;
      host_rvalid   <= 1'b0;
      host_rdata    <= '0;
    end else begin
      mem_read_data <= w_mem_in_range ? r_mem[w_mem_idx] : '0;
      host_rvalid   <= w_host_xfer && !host_we;
      if (w_host_xfer && !host_we)
        host_rdata <= w_host_in_range ? r_mem[w_host_idx] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_count <= '0;
      addr_err <= 1'b0;
    end else begin
      if (w_start_session)
        wr_count <= '0;
      else if (w_hash_wr && w_mem_in_range && (wr_count != 16'hFFFF))
        wr_count <= wr_count + 16'd1;
      // A host access accepted on the start cycle is reported in the new session.
      addr_err <= (addr_err && !w_start_session) || w_err_now;
    end
  end

`ifdef RESULT_MIN_EN
  logic w_min_cand;
  assign w_min_cand = w_hash_wr && w_mem_in_range && (mem_addr >= MIN_BASE);

  // Strict compare keeps the earliest address on ties.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      min_valid <= 1'b0;
      min_data  <= '0;
      min_addr  <= '0;
    end else if (w_start_session) begin
      min_valid <= 1'b0;
      min_data  <= '0;
      min_addr  <= '0;
    end else if (w_min_cand && (!min_valid || (mem_write_data < min_data))) begin
      min_valid <= 1'b1;
      min_data  <= mem_write_data;
      min_addr  <= mem_addr;
    end
  end
`else
  assign min_valid = 1'b0;
  assign min_data  = '0;
  assign min_addr  = '0;
`endif

endmodule

// File: tb/tb_bitcoin_mem_responder.sv
// Directed self-checking bench for bitcoin_mem_responder; host read data checked through a scoreboard queue.
module tb_bitcoin_mem_responder;

`ifdef RESULT_MIN_EN
  localparam int unsigned TB_DEPTH = 1024;
`else
  localparam int unsigned TB_DEPTH = 256;
`endif
  localparam logic [15:0] OOR_ADDR = 16'(TB_DEPTH + 44);

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_we = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [31:0] mem_write_data = '0;
  logic [31:0] mem_read_data;
  logic        hasher_start = 1'b0;
  logic        hasher_done = 1'b0;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [15:0] host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic        host_ready;
  logic        host_rvalid;
  logic [31:0] host_rdata;
  logic        busy;
  logic [15:0] wr_count;
  logic        addr_err;
  logic        min_valid;
  logic [31:0] min_data;
  logic [15:0] min_addr;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  bitcoin_mem_responder #(.DEPTH(TB_DEPTH), .MIN_BASE(16'h0100)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data),
    .hasher_start(hasher_start), .hasher_done(hasher_done),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ready(host_ready), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .busy(busy), .wr_count(wr_count), .addr_err(addr_err),
    .min_valid(min_valid), .min_data(min_data), .min_addr(min_addr)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [15:0] a, input logic [31:0] d);
    host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    tick();
    host_req = 1'b0; host_we = 1'b0;
  endtask

  task automatic host_read(input string tag, input logic [15:0] a, input logic [31:0] exp_val);
    int waited;
    exp_q.push_back(exp_val);
    host_req = 1'b1; host_we = 1'b0; host_addr = a;
    tick();
    host_req = 1'b0;
    waited = 0;
    while (!host_rvalid && waited < 4) begin
      tick();
      waited++;
    end
    check({tag, "_rvalid_latency"}, 32'(waited), 32'd0);
    if (host_rvalid) check({tag, "_rdata"}, host_rdata, exp_q.pop_front());
    else void'(exp_q.pop_front());
  endtask

  task automatic hash_write(input logic [15:0] a, input logic [31:0] d);
    mem_we = 1'b1; mem_addr = a; mem_write_data = d;
    tick();
    mem_we = 1'b0;
  endtask

  task automatic start_session();
    hasher_start = 1'b1;
    tick();
    hasher_start = 1'b0;
  endtask

  task automatic end_session();
    hasher_done = 1'b1;
    tick();
    hasher_done = 1'b0;
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_host_ready", 32'(host_ready), 32'd1);
    check("rst_wr_count", 32'(wr_count), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    check("rst_host_rvalid", 32'(host_rvalid), 32'd0);
    check("rst_mem_read_data", mem_read_data, 32'd0);
    #14 reset_n = 1'b1;
    tick();

    // Host preload/readback and hasher read path
    host_write(16'd5, 32'hDEADBEEF);
    check("rvalid_after_write", 32'(host_rvalid), 32'd0);
    host_read("rd5", 16'd5, 32'hDEADBEEF);
    mem_addr = 16'd5;
    tick();
    check("hasher_rd5", mem_read_data, 32'hDEADBEEF);

    // Ownership: host write on the start cycle still lands
    hasher_start = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'd7; host_wdata = 32'h0000_0077;
    tick();
    hasher_start = 1'b0; host_req = 1'b0; host_we = 1'b0;
    check("own_busy", 32'(busy), 32'd1);
    check("own_host_ready", 32'(host_ready), 32'd0);
    hash_write(16'd7, 32'h0000_1234);
    check("own_old_data7", mem_read_data, 32'h0000_0077);
    tick();
    check("own_new_data7", mem_read_data, 32'h0000_1234);
    check("own_wr_count", 32'(wr_count), 32'd1);
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'd5; host_wdata = 32'h0;
    tick();
    host_req = 1'b0; host_we = 1'b0;
    hasher_start = 1'b1;
    tick();
    hasher_start = 1'b0;
    check("start_in_hash_ignored", 32'(wr_count), 32'd1);
    end_session();
    check("done_busy", 32'(busy), 32'd0);
    check("done_host_ready", 32'(host_ready), 32'd1);
    host_read("rd5_unblocked", 16'd5, 32'hDEADBEEF);

    // Write counting and out-of-range handling
    start_session();
    check("session_clear_wr_count", 32'(wr_count), 32'd0);
    for (int i = 0; i < 4; i++) hash_write(16'd8, 32'h100 + 32'(i));
    hash_write(OOR_ADDR, 32'hBAD0_BAD0);
    check("range_wr_count", 32'(wr_count), 32'd4);
    check("range_addr_err", 32'(addr_err), 32'd1);
    mem_addr = OOR_ADDR;
    tick();
    check("hasher_rd_oor", mem_read_data, 32'd0);
    mem_addr = 16'd8;
    tick();
    check("hasher_rd8", mem_read_data, 32'h103);
    end_session();
    host_read("rd_oor", OOR_ADDR, 32'd0);
    check("addr_err_sticky", 32'(addr_err), 32'd1);

    // Read-during-write, then done beating start, then mem_we ignored in HOST
    start_session();
    check("session_clear_addr_err", 32'(addr_err), 32'd0);
    hash_write(16'd9, 32'h1);
    mem_addr = 16'd9; mem_we = 1'b1; mem_write_data = 32'h2;
    tick();
    mem_we = 1'b0;
    check("rdw_old", mem_read_data, 32'h1);
    tick();
    check("rdw_new", mem_read_data, 32'h2);
    hasher_start = 1'b1; hasher_done = 1'b1;
    tick();
    hasher_start = 1'b0; hasher_done = 1'b0;
    check("done_wins_busy", 32'(busy), 32'd0);
    check("done_wins_wr_count", 32'(wr_count), 32'd2);
    hash_write(16'd9, 32'h3);
    check("host_mem_we_no_count", 32'(wr_count), 32'd2);
    host_read("rd9", 16'd9, 32'h2);

    // Optional minimum scan
    start_session();
    hash_write(16'd256, 32'h50);
    hash_write(16'd257, 32'h20);
    hash_write(16'd258, 32'h20);
    hash_write(16'd10, 32'h10);
`ifdef RESULT_MIN_EN
    check("min_valid", 32'(min_valid), 32'd1);
    check("min_data", min_data, 32'h20);
    check("min_addr", 32'(min_addr), 32'd257);
`else
    check("min_valid_off", 32'(min_valid), 32'd0);
    check("min_data_off", min_data, 32'd0);
    check("min_addr_off", 32'(min_addr), 32'd0);
`endif
    end_session();

    // Reset mid-session keeps array contents
    start_session();
    hash_write(16'd20, 32'hA0);
    hash_write(16'd21, 32'hA1);
    hash_write(16'd22, 32'hA2);
    check("pre_reset_wr_count", 32'(wr_count), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_host_ready", 32'(host_ready), 32'd1);
    check("midrst_wr_count", 32'(wr_count), 32'd0);
    check("midrst_addr_err", 32'(addr_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    host_read("rd21_after_reset", 16'd21, 32'hA1);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
